// File: rtl/brain_pkg.sv
// ============================================================================
// Module      : brain_pkg
// Description : Shared weight-bank geometry and weight loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package brain_pkg;

    localparam int c_num_weights = 30;
    localparam int c_data_w      = 8;
    localparam int c_addr_w      = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage : brain_pkg

`default_nettype wire

// File: rtl/weight_checksum.sv
// ============================================================================
// Module      : weight_checksum
// Description : Modulo-2^DATA_W running sum of weights with a sticky compare
//               against a trailing checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_checksum
    import brain_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add,
    input  logic              cmp,
    input  logic [DATA_W-1:0] data,
    output logic              err
);

    logic [DATA_W-1:0] r_acc;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_err <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_err <= 1'b0;
        end else begin
            if (add) begin
                r_acc <= r_acc + data;
            end
            if (cmp) begin
                r_err <= (data != r_acc);
            end
        end
    end

    assign err = r_err;

endmodule : weight_checksum

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module      : weight_loader
// Description : Start-triggered write master that streams NUM_WEIGHTS weights
//               into a WeightRegBank at addresses 0..NUM_WEIGHTS-1.
//               Optional trailing checksum: WEIGHT_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader
    import brain_pkg::*;
#(
    parameter int NUM_WEIGHTS = c_num_weights,
    parameter int DATA_W      = c_data_w,
    parameter int ADDR_W      = c_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [DATA_W-1:0] wData,
    output logic [ADDR_W-1:0] wAddr,
    output logic              wWrite,
    output logic              busy,
    output logic              done,
    output logic              checksumErr
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_WEIGHTS - 1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_wwrite;

    logic w_ready;
    logic w_busy;
    logic w_done;
    logic w_accept;
    logic w_wt_accept;
    logic w_last;
    logic w_start;

    // Accept qualifiers; the checksum byte is accepted but never written.
    always_comb begin
        w_accept    = inValid && w_ready;
        w_wt_accept = w_accept && (r_state == ST_LOAD);
        w_last      = w_wt_accept && (r_cnt == c_last_addr);
        w_start     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_last) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_FLUSH;
`endif
                end
            end
            ST_CHECK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (w_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter saturates at the last address so no out-of-range write is possible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_waddr  <= '0;
            r_wwrite <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wwrite <= w_wt_accept;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_wt_accept && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wt_accept) begin
                r_wdata <= inData;
                r_waddr <= r_cnt;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic w_ck_err;

    weight_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .add   (w_wt_accept),
        .cmp   (w_accept && (r_state == ST_CHECK)),
        .data  (inData),
        .err   (w_ck_err)
    );

    assign checksumErr = w_ck_err;
`else
    assign checksumErr = 1'b0;
`endif

    assign inReady = w_ready;
    assign busy    = w_busy;
    assign done    = w_done;
    assign wData   = r_wdata;
    assign wAddr   = r_waddr;
    assign wWrite  = r_wwrite;

endmodule : weight_loader

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module      : tb_weight_loader
// Description : Scoreboard bench for weight_loader with a behavioural bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_loader;
    import brain_pkg::*;

    localparam int NW = c_num_weights;
    localparam int DW = c_data_w;
    localparam int AW = c_addr_w;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int c_extra = 1;
`else
    localparam int c_extra = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [DW-1:0] wData;
    logic [AW-1:0] wAddr;
    logic          wWrite;
    logic          busy;
    logic          done;
    logic          checksumErr;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb_q[$];
    logic [DW-1:0] bank     [NW];
    logic [DW-1:0] exp_bank [NW];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_writes = 0;
    int            cyc = 0;

    weight_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .inData      (inData),
        .inValid     (inValid),
        .inReady     (inReady),
        .wData       (wData),
        .wAddr       (wAddr),
        .wWrite      (wWrite),
        .busy        (busy),
        .done        (done),
        .checksumErr (checksumErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Write monitor: every pulse must match the oldest accepted beat.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wWrite === 1'b1) begin
                n_writes++;
                if (sb_q.size() == 0) begin
                    check_eq("extra_write", 32'(wAddr), 32'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("waddr", 32'(wAddr), 32'(e.addr));
                    check_eq("wdata", 32'(wData), 32'(e.data));
                end
                if (int'(wAddr) < NW) bank[wAddr] = wData;
                else check_eq("addr_range", 32'(wAddr), 32'(NW - 1));
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit wr, input logic [AW-1:0] a);
        bit  ok;
        wr_t e;
        ok      = 1'b0;
        inValid = 1'b1;
        inData  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (inReady === 1'b1) begin
                if (wr) begin
                    e.addr = a;
                    e.data = d;
                    sb_q.push_back(e);
                end
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NW; i++) begin
            check_eq(tag, 32'(bank[i]), 32'(exp_bank[i]));
        end
    endtask

    task automatic idle_valid(input int n);
        int w0;
        w0      = n_writes;
        inValid = 1'b1;
        inData  = 8'h5A;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(inReady), 32'd0);
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_no_write", 32'(n_writes - w0), 32'd0);
    endtask

    task automatic run_load(input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input bit gaps, input bit mid_start, input logic [DW-1:0] ck);
        logic [DW-1:0] d;
        logic [DW-1:0] sum;
        logic          exp_err;
        int            t0;
        int            w0;
        sum   = '0;
        d     = base;
        w0    = n_writes;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("ready_after_start", 32'(inReady), 32'd1);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("done_cleared", 32'(done), 32'd0);
        check_eq("ckerr_cleared", 32'(checksumErr), 32'd0);
        for (int i = 0; i < NW; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    inValid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            if (mid_start && i == NW / 2) start = 1'b1;
            send_beat(d, 1'b1, AW'(i));
            start       = 1'b0;
            exp_bank[i] = d;
            sum         = sum + d;
            d           = d + step;
        end
        inValid = 1'b0;
        exp_err = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        exp_err = (ck != sum);
        check_eq("ready_in_check", 32'(inReady), 32'd1);
        send_beat(ck, 1'b0, '0);
        inValid = 1'b0;
        check_eq("ckerr", 32'(checksumErr), 32'(exp_err));
`else
        check_eq("ck_unused", 32'(ck == ck), 32'd1);
`endif
        check_eq("ready_after_last", 32'(inReady), 32'd0);
        check_eq("busy_flush", 32'(busy), 32'd1);
        check_eq("done_flush", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("done", 32'(done), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("ready_done", 32'(inReady), 32'd0);
        check_eq("ckerr_done", 32'(checksumErr), 32'(exp_err));
        if (!gaps) check_eq("latency", 32'(cyc - t0), 32'(NW + 2 + c_extra));
        check_eq("write_count", 32'(n_writes - w0), 32'(NW));
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        check_bank("bank");
    endtask

    initial begin
        int w0;
        for (int i = 0; i < NW; i++) begin
            bank[i]     = '0;
            exp_bank[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(inReady), 32'd0);
        check_eq("rst_wdata", 32'(wData), 32'd0);
        check_eq("rst_waddr", 32'(wAddr), 32'd0);
        check_eq("rst_wwrite", 32'(wWrite), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ckerr", 32'(checksumErr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle_valid(3);
        run_load(8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        idle_valid(4);
        check_eq("done_held", 32'(done), 32'd1);
        run_load(8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5 * 8'd30);
        run_load(8'h40, 8'h01, 1'b0, 1'b1, 8'h00);

        // Reset after ten accepts: earlier writes stay, nothing further lands.
        w0    = n_writes;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_beat(8'h30 + 8'(i), 1'b1, AW'(i));
            exp_bank[i] = 8'h30 + 8'(i);
        end
        inData = 8'hEE;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        check_eq("mrst_ready", 32'(inReady), 32'd0);
        check_eq("mrst_wdata", 32'(wData), 32'd0);
        check_eq("mrst_waddr", 32'(wAddr), 32'd0);
        check_eq("mrst_wwrite", 32'(wWrite), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mrst_idle_done", 32'(done), 32'd0);
        check_eq("mrst_writes", 32'(n_writes - w0), 32'd10);
        check_eq("mrst_sb_empty", 32'(sb_q.size()), 32'd0);
        check_bank("mrst_bank");

        run_load(8'hFF, 8'h00, 1'b0, 1'b0, 8'hE2);
        run_load(8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        run_load(8'h01, 8'h01, 1'b0, 1'b0, 8'hD1);
        run_load(8'h01, 8'h01, 1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_weight_loader

`default_nettype wire
